// File: rtl/alarm_pkg.sv
// alarm_pkg: shared state encoding and time-field constants for the alarm
// controller slice (alarm_controller, sec_tick_gen).
//   state_e     - FSM state encoding (IDLE, RING, SNOOZE, DONE)
//   MAX_HOURS   - largest legal hours value (23)
//   MAX_MINUTES - largest legal minutes value (59)
//   HOUR_W      - bit width of an hours field
//   MIN_W       - bit width of a minutes field
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam int MAX_HOURS   = 23;
    localparam int MAX_MINUTES = 59;
    localparam int HOUR_W      = $clog2(MAX_HOURS + 1);
    localparam int MIN_W       = $clog2(MAX_MINUTES + 1);

endpackage

// File: rtl/alarm_controller_sec_tick_gen.sv
// sec_tick_gen: one-second prescaler. Emits a single-cycle sec_tick every
// TICKS_PER_SEC enabled cycles; restart forces the count back to zero so the
// next tick lands exactly one full second later.
// Ports:
//   clk      - system clock
//   rst      - synchronous active-high reset
//   enable   - count only while high; count holds while low
//   restart  - clear the prescaler on this enabled cycle
//   sec_tick - one-cycle pulse on the last cycle of each second
module sec_tick_gen #(
    parameter int TICKS_PER_SEC = 100000000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic restart,
    output logic sec_tick
);

    localparam int            CW   = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= cnt_d;
        end
    end

    // Not gated by restart: restart is derived from the FSM next state, which
    // itself depends on sec_tick. The FSM discards ticks that lose to buttons.
    assign sec_tick = enable && (cnt_q == LAST);

endmodule

// File: rtl/alarm_controller.sv
// alarm_controller: compares the running time with the stored alarm time,
// rings with a blinking LED, and handles snooze (limited count), stop and
// auto-timeout. Single clock domain.
// Optional feature macro: ALARM_BUZZER_TONE_EN (square-wave buzzer tone).
// Ports:
//   clk, rst                    - clock, synchronous active-high reset
//   enable                      - low freezes prescaler, timers, blink, state, outputs
//   time_hours/time_minutes     - current time
//   alarm_hours/alarm_minutes   - stored alarm time
//   alarm_armed                 - high in clock mode, low in adjust mode
//   stop_btn, snooze_btn        - single-cycle debounced button pulses
//   alarm_led                   - blinking indicator while ringing
//   ringing, snoozing           - state indicators
//   buzzer                      - tone output (0 unless ALARM_BUZZER_TONE_EN)
module alarm_controller
    import alarm_pkg::*;
#(
    parameter int TICKS_PER_SEC    = 100000000,
    parameter int SNOOZE_SEC       = 300,
    parameter int RING_TIMEOUT_SEC = 60,
    parameter int MAX_SNOOZES      = 3
`ifdef ALARM_BUZZER_TONE_EN
    ,
    parameter int TONE_DIV         = 50000
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [HOUR_W-1:0] time_hours,
    input  logic [MIN_W-1:0]  time_minutes,
    input  logic [HOUR_W-1:0] alarm_hours,
    input  logic [MIN_W-1:0]  alarm_minutes,
    input  logic              alarm_armed,
    input  logic              stop_btn,
    input  logic              snooze_btn,
    output logic              alarm_led,
    output logic              ringing,
    output logic              snoozing,
    output logic              buzzer
);

    localparam int RW = (RING_TIMEOUT_SEC > 0) ? $clog2(RING_TIMEOUT_SEC + 1) : 1;
    localparam int SW = (SNOOZE_SEC > 0) ? $clog2(SNOOZE_SEC + 1) : 1;
    localparam int NW = (MAX_SNOOZES > 0) ? $clog2(MAX_SNOOZES + 1) : 1;

    localparam logic [RW-1:0] RING_LIMIT  = RW'(RING_TIMEOUT_SEC);
    localparam logic [SW-1:0] SNOOZE_INIT = SW'(SNOOZE_SEC);
    localparam logic [NW-1:0] SNOOZE_MAX  = NW'(MAX_SNOOZES);

    state_e        state_q, state_d;
    logic          match, match_q;
    logic [RW-1:0] ring_sec_q, ring_sec_d;
    logic [SW-1:0] snooze_sec_q, snooze_sec_d;
    logic [NW-1:0] snooze_cnt_q, snooze_cnt_d;
    logic          blink_q, blink_d;
    logic          alarm_led_q, ringing_q, snoozing_q;
    logic          sec_tick, restart;

    // Saturating second counters: never wrap past their terminal value.
    function automatic logic [RW-1:0] ring_sec_inc(input logic [RW-1:0] v);
        return (v == RING_LIMIT) ? v : v + 1'b1;
    endfunction

    function automatic logic [SW-1:0] snooze_sec_dec(input logic [SW-1:0] v);
        return (v == '0) ? v : v - 1'b1;
    endfunction

    assign match   = alarm_armed && (time_hours == alarm_hours)
                                 && (time_minutes == alarm_minutes);
    assign restart = (state_d != state_q);

    sec_tick_gen #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_sec_tick_gen (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .restart  (restart),
        .sec_tick (sec_tick)
    );

    always_comb begin
        state_d      = state_q;
        ring_sec_d   = ring_sec_q;
        snooze_sec_d = snooze_sec_q;
        snooze_cnt_d = snooze_cnt_q;
        blink_d      = blink_q;

        if (!alarm_armed) begin
            // Disarming beats any button and parks the event cleanly.
            state_d      = IDLE;
            ring_sec_d   = '0;
            snooze_cnt_d = '0;
            blink_d      = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    ring_sec_d   = '0;
                    snooze_cnt_d = '0;
                    blink_d      = 1'b1;
                    if (match_q) begin
                        state_d = RING;
                    end
                end
                RING: begin
                    if (stop_btn) begin
                        state_d = DONE;
                    end else if (snooze_btn) begin
                        if (snooze_cnt_q < SNOOZE_MAX) begin
                            state_d      = SNOOZE;
                            snooze_cnt_d = snooze_cnt_q + 1'b1;
                            snooze_sec_d = SNOOZE_INIT;
                        end else begin
                            state_d = DONE;
                        end
                    end else if (sec_tick) begin
                        blink_d    = ~blink_q;
                        ring_sec_d = ring_sec_inc(ring_sec_q);
                        if (ring_sec_d == RING_LIMIT) begin
                            state_d = DONE;
                        end
                    end
                end
                SNOOZE: begin
                    if (stop_btn) begin
                        state_d = DONE;
                    end else if (sec_tick) begin
                        snooze_sec_d = snooze_sec_dec(snooze_sec_q);
                        if (snooze_sec_d == '0) begin
                            state_d    = RING;
                            ring_sec_d = '0;
                            blink_d    = 1'b1;
                        end
                    end
                end
                DONE: begin
                    // Hold until the minute moves on so the same minute cannot retrigger.
                    if (!match_q) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            match_q <= 1'b0;
        end else begin
            match_q <= match;
        end
    end

    // Outputs are registered from next-state values so they change together
    // with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ring_sec_q   <= '0;
            snooze_sec_q <= '0;
            snooze_cnt_q <= '0;
            blink_q      <= 1'b1;
            alarm_led_q  <= 1'b0;
            ringing_q    <= 1'b0;
            snoozing_q   <= 1'b0;
        end else if (enable) begin
            state_q      <= state_d;
            ring_sec_q   <= ring_sec_d;
            snooze_sec_q <= snooze_sec_d;
            snooze_cnt_q <= snooze_cnt_d;
            blink_q      <= blink_d;
            alarm_led_q  <= (state_d == RING) && blink_d;
            ringing_q    <= (state_d == RING);
            snoozing_q   <= (state_d == SNOOZE);
        end
    end

    assign alarm_led = alarm_led_q;
    assign ringing   = ringing_q;
    assign snoozing  = snoozing_q;

`ifdef ALARM_BUZZER_TONE_EN
    localparam int            TW        = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
    localparam logic [TW-1:0] TONE_LAST = TW'(TONE_DIV - 1);

    logic [TW-1:0] tone_cnt_q;
    logic          buzzer_q;

    // Tone restarts whenever the LED is dark, so each lit phase begins low.
    always_ff @(posedge clk) begin
        if (rst) begin
            tone_cnt_q <= '0;
            buzzer_q   <= 1'b0;
        end else if (enable) begin
            if (!alarm_led_q) begin
                tone_cnt_q <= '0;
                buzzer_q   <= 1'b0;
            end else if (tone_cnt_q == TONE_LAST) begin
                tone_cnt_q <= '0;
                buzzer_q   <= ~buzzer_q;
            end else begin
                tone_cnt_q <= tone_cnt_q + 1'b1;
            end
        end
    end

    assign buzzer = buzzer_q;
`else
    assign buzzer = 1'b0;
`endif

endmodule

// File: tb/tb_alarm_controller.sv
// tb_alarm_controller: directed scenarios followed by randomized stimulus.
// A reference model based on elapsed enabled cycles per mode produces the
// expected outputs for every clock; a monitor compares them on the falling edge.
module tb_alarm_controller;

    localparam int TPS  = 4;
    localparam int SN   = 3;
    localparam int TO   = 5;
    localparam int MAXS = 1;
`ifdef ALARM_BUZZER_TONE_EN
    localparam int TD   = 2;
`endif

    localparam int MD_IDLE = 0;
    localparam int MD_RING = 1;
    localparam int MD_SNZ  = 2;
    localparam int MD_DONE = 3;

    logic       clk = 1'b0;
    logic       rst, enable, alarm_armed, stop_btn, snooze_btn;
    logic [4:0] time_hours, alarm_hours;
    logic [5:0] time_minutes, alarm_minutes;
    logic       alarm_led, ringing, snoozing, buzzer;

    always #5 clk = ~clk;

    alarm_controller #(
        .TICKS_PER_SEC    (TPS),
        .SNOOZE_SEC       (SN),
        .RING_TIMEOUT_SEC (TO),
        .MAX_SNOOZES      (MAXS)
`ifdef ALARM_BUZZER_TONE_EN
        ,
        .TONE_DIV         (TD)
`endif
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .time_hours    (time_hours),
        .time_minutes  (time_minutes),
        .alarm_hours   (alarm_hours),
        .alarm_minutes (alarm_minutes),
        .alarm_armed   (alarm_armed),
        .stop_btn      (stop_btn),
        .snooze_btn    (snooze_btn),
        .alarm_led     (alarm_led),
        .ringing       (ringing),
        .snoozing      (snoozing),
        .buzzer        (buzzer)
    );

    typedef struct packed {
        logic led;
        logic ring;
        logic snz;
        logic buz;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;

    // Reference model state: current mode, enabled cycles spent in it,
    // snoozes used in this alarm event, and last cycle's match.
    int   m_mode = MD_IDLE;
    int   m_elapsed = 0;
    int   m_snz_used = 0;
    bit   m_hit = 1'b0;
    bit   m_led = 1'b0;
    bit   m_ring = 1'b0;
    bit   m_snzo = 1'b0;
    bit   m_buz = 1'b0;
`ifdef ALARM_BUZZER_TONE_EN
    int   m_tone = 0;
`endif

    task automatic model_step();
        bit hit;
        int nxt;
        hit = alarm_armed && (time_hours == alarm_hours) && (time_minutes == alarm_minutes);
        if (rst) begin
            m_mode = MD_IDLE; m_elapsed = 0; m_snz_used = 0; m_hit = 1'b0;
            m_led = 1'b0; m_ring = 1'b0; m_snzo = 1'b0; m_buz = 1'b0;
`ifdef ALARM_BUZZER_TONE_EN
            m_tone = 0;
`endif
        end else begin
            if (enable) begin
`ifdef ALARM_BUZZER_TONE_EN
                if (!m_led) begin
                    m_tone = 0; m_buz = 1'b0;
                end else if (m_tone == TD - 1) begin
                    m_tone = 0; m_buz = !m_buz;
                end else begin
                    m_tone++;
                end
`endif
                nxt = m_mode;
                if (!alarm_armed) begin
                    nxt = MD_IDLE;
                end else begin
                    case (m_mode)
                        MD_IDLE: if (m_hit) begin
                            nxt = MD_RING;
                            m_snz_used = 0;
                        end
                        MD_RING: begin
                            if (stop_btn) nxt = MD_DONE;
                            else if (snooze_btn) begin
                                if (m_snz_used < MAXS) begin
                                    nxt = MD_SNZ;
                                    m_snz_used++;
                                end else begin
                                    nxt = MD_DONE;
                                end
                            end else if (m_elapsed + 1 >= TO * TPS) nxt = MD_DONE;
                        end
                        MD_SNZ: begin
                            if (stop_btn) nxt = MD_DONE;
                            else if (m_elapsed + 1 >= SN * TPS) nxt = MD_RING;
                        end
                        default: if (!m_hit) nxt = MD_IDLE;
                    endcase
                end
                m_elapsed = (nxt != m_mode) ? 0 : m_elapsed + 1;
                m_mode    = nxt;
                m_ring    = (m_mode == MD_RING);
                m_snzo    = (m_mode == MD_SNZ);
                m_led     = m_ring && (((m_elapsed / TPS) % 2) == 0);
            end
            m_hit = hit;
        end
        exp_q.push_back({m_led, m_ring, m_snzo, m_buz});
    endtask

    // One clock: predict, let the edge happen, then drop button pulses.
    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        stop_btn   = 1'b0;
        snooze_btn = 1'b0;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            tests++;
            if ({alarm_led, ringing, snoozing, buzzer} !== mon_e) begin
                fails++;
                $display("FAIL scoreboard t=%0t: led/ring/snz/buz got %b%b%b%b expected %b%b%b%b",
                         $time, alarm_led, ringing, snoozing, buzzer,
                         mon_e.led, mon_e.ring, mon_e.snz, mon_e.buz);
            end
        end
    end

    initial begin
        rst = 1'b1; enable = 1'b1; alarm_armed = 1'b1;
        stop_btn = 1'b0; snooze_btn = 1'b0;
        time_hours = 5'd7; time_minutes = 6'd29;
        alarm_hours = 5'd7; alarm_minutes = 6'd30;
        cyc(); cyc();
        chk("reset_ringing", int'(ringing), 0);
        chk("reset_led", int'(alarm_led), 0);
        chk("reset_snoozing", int'(snoozing), 0);
        chk("reset_buzzer", int'(buzzer), 0);
        rst = 1'b0;

        // Match at 07:30 and the blink pattern.
        time_minutes = 6'd30;
        cyc(); chk("s1_one_cycle_ringing", int'(ringing), 0);
        cyc(); chk("s1_ringing", int'(ringing), 1);
        chk("s1_led_entry", int'(alarm_led), 1);
        repeat (3) cyc(); chk("s1_led_cycle3", int'(alarm_led), 1);
        cyc(); chk("s1_led_cycle4", int'(alarm_led), 0);
        repeat (4) cyc(); chk("s1_led_cycle8", int'(alarm_led), 1);

        // Timeout at 20 cycles, no retrigger in the same minute.
        repeat (11) cyc(); chk("s2_ring_cycle19", int'(ringing), 1);
        cyc(); chk("s2_timeout", int'(ringing), 0);
        repeat (4) cyc(); chk("s2_no_retrigger", int'(ringing), 0);
        time_minutes = 6'd31; repeat (3) cyc();
        time_minutes = 6'd30; repeat (2) cyc();
        chk("s2_rering", int'(ringing), 1);

        // Snooze, return to ring, then the snooze limit acts as stop.
        repeat (2) cyc();
        snooze_btn = 1'b1; cyc();
        chk("s3_snoozing", int'(snoozing), 1);
        chk("s3_not_ringing", int'(ringing), 0);
        repeat (11) cyc(); chk("s3_snooze_cycle11", int'(snoozing), 1);
        cyc(); chk("s3_back_to_ring", int'(ringing), 1);
        chk("s3_snooze_over", int'(snoozing), 0);
        snooze_btn = 1'b1; cyc();
        chk("s3_limit_ringing", int'(ringing), 0);
        chk("s3_limit_snoozing", int'(snoozing), 0);

        // Stop and snooze together: stop wins.
        time_minutes = 6'd31; repeat (3) cyc();
        time_minutes = 6'd30; repeat (2) cyc();
        chk("s4_ringing", int'(ringing), 1);
        stop_btn = 1'b1; snooze_btn = 1'b1; cyc();
        chk("s4_ringing_off", int'(ringing), 0);
        chk("s4_no_snooze", int'(snoozing), 0);
        cyc(); chk("s4_still_no_snooze", int'(snoozing), 0);

        // Disarm while snoozing, re-arm in the same minute, reset mid-ring.
        time_minutes = 6'd31; repeat (3) cyc();
        time_minutes = 6'd30; repeat (2) cyc();
        snooze_btn = 1'b1; cyc();
        chk("s5_snoozing", int'(snoozing), 1);
        alarm_armed = 1'b0; cyc();
        chk("s5_disarm_snoozing", int'(snoozing), 0);
        chk("s5_disarm_ringing", int'(ringing), 0);
        chk("s5_disarm_led", int'(alarm_led), 0);
        alarm_armed = 1'b1; repeat (2) cyc();
        chk("s5_rearm_rings", int'(ringing), 1);
        repeat (5) cyc(); chk("s5_led_dark_phase", int'(alarm_led), 0);
        rst = 1'b1; cyc(); rst = 1'b0;
        chk("s5_rst_ringing", int'(ringing), 0);
        chk("s5_rst_led", int'(alarm_led), 0);
        repeat (2) cyc();
        chk("s5_ring_after_rst", int'(ringing), 1);
        chk("s5_blink_restart", int'(alarm_led), 1);

        // Enable low freezes everything; timeout after 20 enabled cycles.
        repeat (2) cyc();
        enable = 1'b0; repeat (10) cyc();
        chk("s6_frozen_ringing", int'(ringing), 1);
        chk("s6_frozen_led", int'(alarm_led), 1);
        enable = 1'b1; repeat (17) cyc();
        chk("s6_enabled_cycle19", int'(ringing), 1);
        cyc(); chk("s6_timeout", int'(ringing), 0);

        // Randomized phase, checked by the scoreboard only.
        for (int i = 0; i < 4000; i++) begin
            rst    = ($urandom_range(0, 599) == 0);
            enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 99) == 0) alarm_armed = ~alarm_armed;
            if ($urandom_range(0, 29) == 0)
                time_minutes = ($urandom_range(0, 2) == 0) ? 6'd31 : 6'd30;
            if ($urandom_range(0, 199) == 0)
                time_hours = ($urandom_range(0, 3) == 0) ? 5'd8 : 5'd7;
            stop_btn   = ($urandom_range(0, 79) == 0);
            snooze_btn = ($urandom_range(0, 19) == 0);
            cyc();
        end

        rst = 1'b0; enable = 1'b1;
        @(negedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
